serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock through a chain of `fa` cells. Carry is held in a flip-flop between digits. A WIDTH-bit add or subtract completes in WIDTH/DIGIT cycles. It is the sequential, width-generic successor to the single-bit full adder. It sits behind simple start/done control for small datapaths where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits
- DIGIT, 1, bits processed per cycle; must divide WIDTH (elaboration error otherwise)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only when busy=0
- sub  in  1  0: s = x + y + ci; 1: s = x + ~y + 1 (ci ignored)
- ci  in  1  carry in (add mode)
- x  in  WIDTH  operand
- y  in  WIDTH  operand
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, results valid
- s  out  WIDTH  sum/difference
- co  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement overflow

## Operation
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, s=0, co=0, ovf=0, digit counter=0, carry FF=0.
- States: IDLE, RUN.
- IDLE with start=1:
  - capture x and y into shift registers; if sub=1, store ~y.
  - carry FF := (sub ? 1 : ci).
  - go to RUN, busy=1.
- IDLE with start=0: hold; outputs unchanged.
- RUN, each cycle:
  - the low DIGIT bits of the x/y registers plus the carry FF feed the DIGIT-cell `fa` chain.
  - the sum digit shifts into the result register from the MSB end.
  - carry FF := chain carry-out; x/y registers shift right by DIGIT; counter increments.
- Last digit (counter = WIDTH/DIGIT-1):
  - s := completed result register; co := final carry.
  - ovf := carry into MSB XOR carry out of MSB.
  - state IDLE, busy=0, done=1 for exactly the next cycle.
- start while busy=1: ignored. No queuing; inputs are not re-sampled.
- start in the done cycle: accepted, since the state is IDLE. done and busy are both high in the following cycle only if a new result also completes then, which is impossible for N≥1. The new run begins normally.
- s/co/ovf hold their last values until the next completion. They do not change during RUN.
- Reset mid-RUN: abort immediately to reset values; no done pulse.
- Arithmetic is modulo 2^WIDTH. ovf is computed identically in both modes, because sub is folded into the operand and carry.

## Timing
- N = WIDTH/DIGIT.
- start sampled high at edge t → busy high from t+1 through t+N. done high in cycle t+N+1, with s/co/ovf valid.
- Throughput: one operation per N+1 cycles; back-to-back starts give N+1 cycles between accepted starts.
- done is a registered output, never combinational from start.
- The critical path is DIGIT `fa` cells plus the carry FF. There is no path spanning the full WIDTH.

## Structure
- Package serial_adder_pkg holds:
  - state typedef (IDLE, RUN);
  - a function giving the counter width, clog2(WIDTH/DIGIT) with a minimum of 1.
- One sub-module, fa_slice:
  - parameter DIGIT; DIGIT existing `fa` instances in a ripple chain;
  - ports ci, x[DIGIT], y[DIGIT], s[DIGIT], co, c_msb_in;
  - c_msb_in is the carry into the top cell, used for ovf.
- Top level: FSM, counter, operand/result shift registers, output registers.

## Test plan
- WIDTH=8, DIGIT=1, add: x=0x0F, y=0x01, ci=0 → done 9 cycles after start; s=0x10, co=0, ovf=0.
- Add: x=0xFF, y=0x01, ci=0 → s=0x00, co=1, ovf=0. Then x=0x7F, y=0x01 → s=0x80, co=0, ovf=1.
- Sub: x=0x05, y=0x07 → s=0xFE, co=0, ovf=0. Then x=0x80, y=0x01 → s=0x7F, co=1, ovf=1.
- WIDTH=8, DIGIT=4: x=0x3C, y=0x44, ci=1 → done 3 cycles after start; s=0x81, co=0, ovf=1.
- Control, WIDTH=8, DIGIT=1:
  - start pulsed again 3 cycles into a run → ignored; single done with the first result.
  - start in the done cycle → second result completes 9 cycles later.
  - rst_n=0 mid-run → busy=0, s=0, no done.
- WIDTH=4, DIGIT=1 and DIGIT=2: exhaustive sweep of all x, y, ci, sub (1024 cases per config) against a reference model; s, co and ovf must match.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter sizing shared by the serial adder
package serial_adder_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int width, input int digit);
    return (width / digit) > 1 ? $clog2(width / digit) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and result bundle of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8) ();
  logic start;
  logic sub;
  logic ci;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic busy;
  logic done;
  logic [WIDTH-1:0] s;
  logic co;
  logic ovf;
  modport master (output start, sub, ci, x, y, input busy, done, s, co, ovf);
  modport slave (input start, sub, ci, x, y, output busy, done, s, co, ovf);
endinterface

// File: rtl/fa.sv
// fa: single-bit full adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/fa_slice.sv
// fa_slice: DIGIT-bit ripple chain of fa cells, exposing the carry into the top cell
module fa_slice #(parameter int DIGIT = 1) (
  input  logic ci,
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic [DIGIT-1:0] s,
  output logic co,
  output logic c_msb_in
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa u_fa (.a(x[i]), .b(y[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock with a carry flip-flop
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] xr, yr, res, s_q;
  logic [CW-1:0] cnt;
  logic carry, co_q, ovf_q, done_q;
  logic load, step, last;
  logic [DIGIT-1:0] sd;
  logic cd, cm;
  logic [WIDTH+DIGIT-1:0] cat;
  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .ci(carry), .x(xr[DIGIT-1:0]), .y(yr[DIGIT-1:0]),
    .s(sd), .co(cd), .c_msb_in(cm)
  );
  // sum digit enters at the MSB end so the finished word lines up after N shifts
  assign cat = {sd, res};
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    state_nx = state;
    load = (state == IDLE) && bus.start;
    step = (state == RUN);
    last = step && (cnt == LAST);
    state_nx = load ? RUN : last ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      xr <= '0;
      yr <= '0;
      res <= '0;
      s_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        xr <= bus.x;
        yr <= bus.sub ? ~bus.y : bus.y;
        carry <= bus.sub | bus.ci;
        cnt <= '0;
      end else if (step) begin
        xr <= xr >> DIGIT;
        yr <= yr >> DIGIT;
        res <= cat[WIDTH+DIGIT-1:DIGIT];
        carry <= cd;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (last) begin
        s_q <= cat[WIDTH+DIGIT-1:DIGIT];
        co_q <= cd;
        ovf_q <= cm ^ cd;
      end
    end
  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.s = s_q;
  assign bus.co = co_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors, control corner cases and 4-bit sweeps over four configurations
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] start = '0;
  logic sub = 1'b0;
  logic ci = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) b0 ();
  serial_adder_if #(.WIDTH(8)) b1 ();
  serial_adder_if #(.WIDTH(4)) b2 ();
  serial_adder_if #(.WIDTH(4)) b3 ();
  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  assign {b0.start, b1.start, b2.start, b3.start} = {start[0], start[1], start[2], start[3]};
  assign {b0.sub, b1.sub, b2.sub, b3.sub} = {4{sub}};
  assign {b0.ci, b1.ci, b2.ci, b3.ci} = {4{ci}};
  assign {b0.x, b1.x, b2.x, b3.x} = {x, x, x[3:0], x[3:0]};
  assign {b0.y, b1.y, b2.y, b3.y} = {y, y, y[3:0], y[3:0]};
  logic [3:0] busy_v, done_v, co_v, ovf_v;
  logic [7:0] s_v [4];
  assign busy_v = {b3.busy, b2.busy, b1.busy, b0.busy};
  assign done_v = {b3.done, b2.done, b1.done, b0.done};
  assign co_v = {b3.co, b2.co, b1.co, b0.co};
  assign ovf_v = {b3.ovf, b2.ovf, b1.ovf, b0.ovf};
  assign s_v[0] = b0.s;
  assign s_v[1] = b1.s;
  assign s_v[2] = {4'h0, b2.s};
  assign s_v[3] = {4'h0, b3.s};

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // launch one operation on DUT k and wait (bounded) for its done pulse
  task automatic op(input int k, input logic [7:0] xa, input logic [7:0] ya, input logic cia,
                    input logic suba, output logic [7:0] so, output logic coo, output logic ovo,
                    output int lat);
    @(negedge clk);
    x = xa; y = ya; ci = cia; sub = suba; start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    lat = 1;
    while (!done_v[k] && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    so = s_v[k]; coo = co_v[k]; ovo = ovf_v[k];
  endtask

  typedef struct {
    int k;
    logic [7:0] x, y;
    logic ci, sub;
    logic [7:0] s;
    logic co, ovf;
    int lat;
  } vec_t;
  vec_t vt [8];

  initial begin
    logic [7:0] so;
    logic coo, ovo;
    int lat, dn, first;
    vt[0] = '{0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 9};
    vt[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9};
    vt[2] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 9};
    vt[3] = '{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 9};
    vt[4] = '{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 9};
    vt[5] = '{0, 8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0, 9};
    vt[6] = '{1, 8'h3C, 8'h44, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 3};
    vt[7] = '{1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 3};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset busy", 16'(busy_v), 16'h0);
    chk("reset done", 16'(done_v), 16'h0);
    chk("reset s", {s_v[0], s_v[1]}, 16'h0);
    chk("reset co/ovf", {co_v, ovf_v}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      op(vt[i].k, vt[i].x, vt[i].y, vt[i].ci, vt[i].sub, so, coo, ovo, lat);
      chk($sformatf("vec%0d s/co/ovf", i), {6'h0, so, coo, ovo}, {6'h0, vt[i].s, vt[i].co, vt[i].ovf});
      chk($sformatf("vec%0d latency", i), 16'(lat), 16'(vt[i].lat));
    end
    // start pulsed 3 cycles into a run is ignored
    @(negedge clk);
    x = 8'h11; y = 8'h22; ci = 1'b0; sub = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    dn = 0; first = -1; so = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done_v[0]) begin dn++; first = c; so = s_v[0]; end
      if (c == 3) begin x = 8'hAA; y = 8'h01; start[0] = 1'b1; end
      @(posedge clk); #1 start[0] = 1'b0;
    end
    chk("ignore dones", 16'(dn), 16'd1);
    chk("ignore latency", 16'(first), 16'd9);
    chk("ignore s", 16'(so), 16'h33);
    // start in the done cycle begins a new run
    op(0, 8'h01, 8'h02, 1'b0, 1'b0, so, coo, ovo, lat);
    chk("b2b first s", 16'(so), 16'h03);
    x = 8'h40; y = 8'h40; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    chk("b2b done/busy after", {done_v[0], busy_v[0]}, 16'b01);
    lat = 1;
    while (!done_v[0] && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    chk("b2b latency", 16'(lat), 16'd9);
    chk("b2b s/co/ovf", {s_v[0], co_v[0], ovf_v[0]}, {8'h80, 1'b0, 1'b1});
    // reset mid-run aborts with no done
    @(negedge clk);
    x = 8'hFF; y = 8'hFF; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst busy/done", {busy_v[0], done_v[0]}, 16'h0);
    chk("rst s/co/ovf", {s_v[0], co_v[0], ovf_v[0]}, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 if (done_v[0] || busy_v[0]) dn++;
    end
    chk("rst no done", 16'(dn), 16'd0);
    // exhaustive 4-bit sweeps against an arithmetic model
    for (int k = 2; k <= 3; k++)
      for (int v = 0; v < 1024; v++) begin
        logic [3:0] xa, ya, yy, es;
        logic cia, suba;
        int sum;
        {suba, cia, xa, ya} = v[9:0];
        yy = suba ? ~ya : ya;
        sum = int'(xa) + int'(yy) + ((suba || cia) ? 1 : 0);
        es = sum[3:0];
        op(k, {4'h0, xa}, {4'h0, ya}, cia, suba, so, coo, ovo, lat);
        chk($sformatf("sweep d%0d x%0h y%0h c%0b m%0b", k == 2 ? 1 : 2, xa, ya, cia, suba),
            {3'h0, so, coo, ovo, lat[2:0]},
            {3'h0, 4'h0, es, sum[4], (xa[3] == yy[3]) && (es[3] != xa[3]), k == 2 ? 3'd5 : 3'd3});
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
